shot_pool: RTL
==============

# shot_pool

Parametrised pool of projectile entities for the asteroids game. It accepts fire requests through a valid/ack handshake and allocates the lowest free slot. On every frame tick it advances each live shot by its direction vector and retires shots on lifetime expiry, explicit delete or screen exit. It sits between the ship controller (fire, tip position, heading) and the collision/render path, which reads the packed slot array every cycle.

## Interface
Parameters:
- SHOT_COUNT, 16, number of slots (2..64)
- SCREEN_W, 640, horizontal extent in pixels, legal x is 0..SCREEN_W-1
- SCREEN_H, 480, vertical extent in pixels, legal y is 0..SCREEN_H-1
- LIFETIME, 120, ticks a shot lives; must be ≥1 and fit in LIFE_W
- COOLDOWN, 4, ticks after an accepted fire before the next is accepted; 0 disables cooldown

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- tick  in  1  one-cycle frame-step strobe
- fire  in  1  fire request, level
- fire_ack  out  1  fire accepted this cycle (combinational)
- owner  in  3  entity tag stored in the shot
- direction  in  6  {ysign, ymag[1:0], xsign, xmag[1:0]}; sign 1 means decreasing
- xtip, ytip  in  COORD_W each  spawn position
- delete_en  in  1  free slot delete_idx
- delete_idx  in  $clog2(SHOT_COUNT)  slot to free
- shots_data  out  SHOT_COUNT × shot_t  slot contents
- active_mask  out  SHOT_COUNT  valid bit of each slot
- active_count  out  $clog2(SHOT_COUNT+1)  popcount of active_mask
- full  out  1  all slots valid

## Operation
- Reset (reset_n low at a clk edge) clears all slots to zero and the cooldown counter to 0. Reset overrides every other input in that cycle. All outputs read 0 after reset, except fire_ack, which is combinational and is also 0 while full.
- Accept: fire_ack = fire & ~full & (cool == 0), evaluated on registered state. On an accepted fire:
  - the lowest-index slot with valid == 0 at cycle start is loaded with valid=1, owner, life=LIFETIME, xq=yq=0, x=xtip, y=ytip, dir=direction;
  - cool loads COOLDOWN.
- A slot freed in the same cycle is not reusable until the next cycle.
- Step: on tick, for each slot valid at cycle start and not loaded this cycle:
  - life decrements; if life was 1, the slot frees.
  - Otherwise the slot takes exactly one of these actions:
    - xq == 0 and yq == 0: load xq = xmag, yq = ymag; position unchanged.
    - xq != 0: x moves ±1 per xsign; xq decrements.
    - otherwise yq != 0: y moves ±1 per ysign; yq decrements.
- Zero direction: the shot never moves and only ages.
- Cooldown: cool decrements on tick while nonzero.
- Delete: delete_en frees slot delete_idx by clearing the whole slot. Deleting an invalid slot or an index ≥ SHOT_COUNT is a no-op.
- Priority per slot: reset > delete > expiry/exit > step.
- Arithmetic: coordinates are unsigned COORD_W. The screen edge behaviour is set under Configuration.

## Timing
- An accepted fire is visible in shots_data and active_mask on the cycle after the accepting edge.
- Tick effects are visible on the cycle after the tick edge.
- active_count and full are derived combinationally from registered active_mask.
- fire held high with cooldown 0 fires once per cycle until full.
- A tick in the same cycle as an accept also decrements cool, but cool loads COOLDOWN, so the load wins.

## Configuration
- SHOT_WRAP_EN defined: a step past an edge wraps. x+1 at SCREEN_W-1 gives 0; x-1 at 0 gives SCREEN_W-1. y wraps the same way against SCREEN_H.
- SHOT_WRAP_EN undefined: a step that would leave the legal range frees the slot instead.

## Structure
- shot_pkg holds:
  - localparams COORD_W=10 and LIFE_W=8;
  - packed struct shot_t {valid, owner[2:0], life[LIFE_W-1:0], yq[1:0], xq[1:0], y, x, dir[5:0]};
  - direction field index constants.
- Sub-module shot_slot: one instance per slot. It holds a single shot_t register with load, step, wrap/exit and free logic.
- Top level holds the priority allocator, the cooldown counter and the popcount.

## Test plan
- Reset: reset_n=0 for 1 cycle with fire=1 → all outputs 0; a fire_ack sampled after reset goes high and allocates slot 0.
- Allocation, SHOT_COUNT=4, COOLDOWN=0: fire=1 for 5 cycles → slots 0..3 valid, full=1 on the 5th cycle, fire_ack=0 there; delete_idx=2 → next fire lands in slot 2.
- Motion, direction=6'b0_01_0_10, spawn (100,50), tick every cycle:
  - tick 1 → load xq=2, yq=1, position unchanged;
  - ticks 2-4 → (101,50), (102,50), (102,51);
  - tick 5 reloads.
- Lifetime, LIFETIME=3: fire then 3 ticks → slot frees on tick 3 and active_count returns to 0.
- Edge: xsign=1, spawn x=0, tick to step → with SHOT_WRAP_EN x=639; without it the slot frees.
- Cooldown, COOLDOWN=2 with fire held: ack, then no ack for 2 ticks, then ack. Simultaneous delete of slot 0 and fire with slots 0..2 valid → new shot goes to slot 3.

Source files
------------

// File: rtl/shot_pkg.sv
// Shared types for the shot pool: slot record, direction field layout and edge-step helper.
package shot_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned LIFE_W  = 8;

  // direction = {ysign, ymag[1:0], xsign, xmag[1:0]}; sign 1 means decreasing
  localparam int unsigned DIR_XMAG  = 0;
  localparam int unsigned DIR_XSIGN = 2;
  localparam int unsigned DIR_YMAG  = 3;
  localparam int unsigned DIR_YSIGN = 5;

  typedef struct packed {
    logic               valid;
    logic [2:0]         owner;
    logic [LIFE_W-1:0]  life;
    logic [1:0]         yq;
    logic [1:0]         xq;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
    logic [5:0]         dir;
  } shot_t;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_RELOAD,
    ACT_MOVE_X,
    ACT_MOVE_Y
  } step_t;

  // Returns {crossed_edge, next}; next is already the wrapped value when an edge is crossed.
  function automatic logic [COORD_W:0] step_coord(input logic [COORD_W-1:0] c,
                                                  input logic dec,
                                                  input logic [COORD_W-1:0] cmax);
    logic edge_hit;
    logic [COORD_W-1:0] next;
    edge_hit = dec ? (c == '0) : (c == cmax);
    if (edge_hit) next = dec ? cmax : '0;
    else          next = dec ? c - COORD_W'(1) : c + COORD_W'(1);
    return {edge_hit, next};
  endfunction

endpackage

// File: rtl/shot_slot.sv
// One projectile slot: load, per-tick aging and stepping, edge wrap or exit (SHOT_WRAP_EN), delete.
module shot_slot
  import shot_pkg::*;
#(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned LIFETIME = 120
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               load,
  input  logic               del,
  input  logic [2:0]         owner,
  input  logic [5:0]         direction,
  input  logic [COORD_W-1:0] xtip,
  input  logic [COORD_W-1:0] ytip,
  output shot_t              shot
);

  localparam logic [COORD_W-1:0] XMAX = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(SCREEN_H - 1);

  shot_t            stepped;
  step_t            act;
  logic             gone;
  logic [COORD_W:0] xs;
  logic [COORD_W:0] ys;

  always_comb begin
    stepped      = shot;
    gone         = 1'b0;
    act          = ACT_HOLD;
    stepped.life = shot.life - LIFE_W'(1);
    xs = step_coord(shot.x, shot.dir[DIR_XSIGN], XMAX);
    ys = step_coord(shot.y, shot.dir[DIR_YSIGN], YMAX);
    if (shot.life == LIFE_W'(1))              gone = 1'b1;
    else if (shot.xq == '0 && shot.yq == '0)  act  = ACT_RELOAD;
    else if (shot.xq != '0)                   act  = ACT_MOVE_X;
    else                                      act  = ACT_MOVE_Y;
    case (act)
      ACT_RELOAD: begin
        stepped.xq = shot.dir[DIR_XMAG +: 2];
        stepped.yq = shot.dir[DIR_YMAG +: 2];
      end
      ACT_MOVE_X: begin
        stepped.xq = shot.xq - 2'd1;
        stepped.x  = xs[COORD_W-1:0];
`ifndef SHOT_WRAP_EN
        gone = xs[COORD_W];
`endif
      end
      ACT_MOVE_Y: begin
        stepped.yq = shot.yq - 2'd1;
        stepped.y  = ys[COORD_W-1:0];
`ifndef SHOT_WRAP_EN
        gone = ys[COORD_W];
`endif
      end
      default: ;
    endcase
  end

  // Delete only acts on a live slot so a same-cycle load into a free slot is never lost.
  always_ff @(posedge clk) begin
    if (!reset_n)                shot <= '0;
    else if (del && shot.valid)  shot <= '0;
    else if (load)               shot <= '{valid: 1'b1, owner: owner, life: LIFE_W'(LIFETIME),
                                           yq: 2'd0, xq: 2'd0, y: ytip, x: xtip, dir: direction};
    else if (tick && shot.valid) shot <= gone ? '0 : stepped;
  end

endmodule

// File: rtl/shot_pool.sv
// Projectile pool: lowest-free-slot allocator, fire cooldown and occupancy count.
// Edge behaviour selected by SHOT_WRAP_EN (defined: wrap, undefined: shot exits).
module shot_pool
  import shot_pkg::*;
#(
  parameter int unsigned SHOT_COUNT = 16,
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned LIFETIME   = 120,
  parameter int unsigned COOLDOWN   = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            tick,
  input  logic                            fire,
  output logic                            fire_ack,
  input  logic [2:0]                      owner,
  input  logic [5:0]                      direction,
  input  logic [COORD_W-1:0]              xtip,
  input  logic [COORD_W-1:0]              ytip,
  input  logic                            delete_en,
  input  logic [$clog2(SHOT_COUNT)-1:0]   delete_idx,
  output shot_t [SHOT_COUNT-1:0]          shots_data,
  output logic [SHOT_COUNT-1:0]           active_mask,
  output logic [$clog2(SHOT_COUNT+1)-1:0] active_count,
  output logic                            full
);

  localparam int unsigned IDX_W  = $clog2(SHOT_COUNT);
  localparam int unsigned CNT_W  = $clog2(SHOT_COUNT + 1);
  localparam int unsigned COOL_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic [COOL_W-1:0]     cool;
  logic [SHOT_COUNT-1:0] load;
  logic                  found;

  assign full     = &active_mask;
  assign fire_ack = fire & ~full & (cool == '0);

  always_comb begin
    load  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < SHOT_COUNT; i++) begin
      if (fire_ack && !active_mask[i] && !found) begin
        load[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    active_count = '0;
    for (int unsigned i = 0; i < SHOT_COUNT; i++)
      active_count = active_count + CNT_W'(active_mask[i]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                  cool <= '0;
    else if (fire_ack)             cool <= COOL_W'(COOLDOWN);
    else if (tick && cool != '0)   cool <= cool - COOL_W'(1);
  end

  for (genvar i = 0; i < SHOT_COUNT; i++) begin : g_slot
    shot_slot #(
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H),
      .LIFETIME (LIFETIME)
    ) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick),
      .load      (load[i]),
      .del       (delete_en && delete_idx == IDX_W'(i)),
      .owner     (owner),
      .direction (direction),
      .xtip      (xtip),
      .ytip      (ytip),
      .shot      (shots_data[i])
    );
    assign active_mask[i] = shots_data[i].valid;
  end

endmodule
